// File: rtl/pu_pipe_n_if.sv
// Handshake/bus bundle for the N-input neuron processing unit.
// The master drives the input vector, weight load and output ready; the slave is the unit.
interface pu_pipe_n_if #(
   parameter int unsigned N_IN = 4
);
   localparam int unsigned AW = 32 * N_IN;

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] a_in;
   logic [1:0]    act_mode;
   logic          w_we;
   logic [AW-1:0] w_in;
   logic [31:0]   bias_in;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic          busy;

   modport master (
      output in_valid, a_in, act_mode, w_we, w_in, bias_in, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, a_in, act_mode, w_we, w_in, bias_in, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/pu_pipe_n.sv
// Pipelined neuron: act(sum a_i*w_i + bias) in single precision, registered adder tree,
// one global stall for all stages. Also holds the fp_mult / fp_adder helpers (RNE, FTZ).
module pu_pipe_n #(
   parameter int unsigned N_IN    = 4,
   parameter bit          BIAS_EN = 1'b1
) (
   input logic        clk,
   input logic        rst_n,
   pu_pipe_n_if.slave bus
);
   localparam int unsigned LOG2N = $clog2(N_IN);
   localparam int unsigned DEPTH = LOG2N + 1;

   logic [31:0]      prod_c [N_IN];
   logic [31:0]      sum_c  [1:LOG2N][N_IN];
   logic [31:0]      lvl_q  [DEPTH][N_IN];
   logic [31:0]      lvl_d  [DEPTH][N_IN];
   logic [1:0]       mode_q [DEPTH];
   logic [1:0]       mode_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [31:0]      w_q [N_IN];
   logic [31:0]      w_d [N_IN];
   logic [31:0]      bias_q, bias_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             adv_c;
   logic [31:0]      bias_c, fin_c, act_c;

   for (genvar i = 0; i < N_IN; i++) begin : g_mul
      fp_mult u_mul (.a(bus.a_in[32*i +: 32]), .b(w_q[i]), .y(prod_c[i]));
   end

   // Level j sums adjacent pairs of level j-1; unused slots are tied off.
   for (genvar j = 1; j <= LOG2N; j++) begin : g_lvl
      for (genvar k = 0; k < N_IN; k++) begin : g_node
         if (k < (N_IN >> j)) begin : g_add
            fp_adder u_add (.a(lvl_q[j-1][2*k]), .b(lvl_q[j-1][2*k+1]), .y(sum_c[j][k]));
         end else begin : g_nil
            assign sum_c[j][k] = 32'd0;
         end
      end
   end

   assign bias_c = BIAS_EN ? bias_q : 32'd0;
   fp_adder u_fin (.a(lvl_q[LOG2N][0]), .b(bias_c), .y(fin_c));

   always_comb begin
      act_c = fin_c;
      case (mode_q[LOG2N])
         2'b01:   act_c = fin_c[31] ? 32'd0 : fin_c;
         2'b10:   act_c = (~fin_c[31] & (|fin_c[30:0])) ? 32'h3F800000 : 32'd0;
         default: act_c = fin_c;
      endcase
   end

   assign adv_c = ~out_valid_q | bus.out_ready;

   // Every stage moves together on adv_c; weight writes ignore the stall.
   always_comb begin
      lvl_d       = lvl_q;
      mode_d      = mode_q;
      vld_d       = vld_q;
      w_d         = w_q;
      bias_d      = bias_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (adv_c) begin
         vld_d[0]  = bus.in_valid;
         mode_d[0] = bus.act_mode;
         for (int i = 0; i < N_IN; i++) lvl_d[0][i] = prod_c[i];
         for (int j = 1; j < DEPTH; j++) begin
            vld_d[j]  = vld_q[j-1];
            mode_d[j] = mode_q[j-1];
            for (int k = 0; k < N_IN; k++) lvl_d[j][k] = sum_c[j][k];
         end
         out_valid_d = vld_q[LOG2N];
         if (vld_q[LOG2N]) out_data_d = act_c;
      end
      if (bus.w_we) begin
         for (int i = 0; i < N_IN; i++) w_d[i] = bus.w_in[32*i +: 32];
         bias_d = bus.bias_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         bias_q      <= 32'd0;
         for (int i = 0; i < N_IN; i++) w_q[i] <= 32'd0;
         for (int j = 0; j < DEPTH; j++) begin
            mode_q[j] <= 2'b00;
            for (int k = 0; k < N_IN; k++) lvl_q[j][k] <= 32'd0;
         end
      end else begin
         vld_q       <= vld_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         bias_q      <= bias_d;
         w_q         <= w_d;
         mode_q      <= mode_d;
         lvl_q       <= lvl_d;
      end
   end

   assign bus.in_ready  = adv_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (|vld_q) | out_valid_q;
endmodule

// Single-precision multiply, round-to-nearest-even, denormals flushed to zero.
module fp_mult (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic              s, g, st;
   logic [47:0]       p;
   logic signed [9:0] e;
   logic [23:0]       m;
   logic [24:0]       mr;

   always_comb begin
      s = a[31] ^ b[31];
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = $signed(10'(a[30:23])) + $signed(10'(b[30:23])) - 10'sd127;
      if (p[47]) begin
         m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
      end else begin
         m = p[46:23]; g = p[22]; st = |p[21:0];
      end
      mr = {1'b0, m} + 25'(g & (st | m[0]));
      if (mr[24]) begin
         m = mr[24:1]; e = e + 10'sd1;
      end else begin
         m = mr[23:0];
      end
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
             a[30:23] == 8'd0 || b[30:23] == 8'd0)
            y = 32'h7FC00000;
         else
            y = {s, 8'hFF, 23'd0};
      end else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) y = {s, 31'd0};
      else if (e >= 10'sd255)                              y = {s, 8'hFF, 23'd0};
      else if (e <= 10'sd0)                                y = {s, 31'd0};
      else                                                 y = {s, e[7:0], m[22:0]};
   end
endmodule

// Single-precision add, round-to-nearest-even, denormals flushed; exact cancellation gives +0.
module fp_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic [31:0]       x, z;
   logic [7:0]        d;
   logic [26:0]       mx, mz, sh;
   logic [27:0]       r;
   logic signed [9:0] e;
   logic [23:0]       m;
   logic [24:0]       mr;
   logic [4:0]        n;
   logic              stk, found;

   always_comb begin
      if (a[30:0] >= b[30:0]) begin x = a; z = b; end
      else                    begin x = b; z = a; end
      mx    = {1'b1, x[22:0], 3'b000};
      mz    = {1'b1, z[22:0], 3'b000};
      d     = x[30:23] - z[30:23];
      sh    = (d > 8'd26) ? 27'd0 : (mz >> d);
      stk   = (d > 8'd26) ? 1'b1 : ((sh << d) != mz);
      sh[0] = sh[0] | stk;
      r     = (x[31] == z[31]) ? ({1'b0, mx} + {1'b0, sh}) : ({1'b0, mx} - {1'b0, sh});
      e     = $signed(10'(x[30:23]));
      n     = 5'd0;
      found = 1'b0;
      if (r[27]) begin
         r = {1'b0, r[27:2], r[1] | r[0]};
         e = e + 10'sd1;
      end else begin
         for (int i = 26; i >= 0; i--)
            if (!found && r[i]) begin found = 1'b1; n = 5'(26 - i); end
         r = r << n;
         e = e - $signed(10'(n));
      end
      m  = r[26:3];
      mr = {1'b0, m} + 25'(r[2] & ((|r[1:0]) | m[0]));
      if (mr[24]) begin
         m = mr[24:1]; e = e + 10'sd1;
      end else begin
         m = mr[23:0];
      end
      if (x[30:23] == 8'hFF) begin
         if (x[22:0] != 23'd0 || (z[30:23] == 8'hFF && z[31] != x[31])) y = 32'h7FC00000;
         else                                                          y = x;
      end else if (x[30:23] == 8'd0) y = {x[31] & z[31], 31'd0};
      else if (z[30:23] == 8'd0)      y = x;
      else if (r == 28'd0)            y = 32'd0;
      else if (e >= 10'sd255)         y = {x[31], 8'hFF, 23'd0};
      else if (e <= 10'sd0)           y = {x[31], 31'd0};
      else                            y = {x[31], e[7:0], m[22:0]};
   end
endmodule
